rr_dispatcher: RTL and testbench
================================

Name: rr_dispatcher

Overview:
- Round-robin dispatcher: the 1-to-N counterpart of the team's N-to-1 round-robin arbiter.
- Accepts one valid/ready input stream and distributes each accepted word to one of NUM_PORTS output ports in rotating order.
- Ports that cannot take a word this cycle are skipped.
- Each output port has a one-entry registered slot. Sits in front of replicated worker units (e.g. parallel processing lanes).

Parameters:
- NUM_PORTS, 4, number of output ports; legal range 2..16; need not be a power of two.
- DATA_W, 8, payload width in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid_i  input  1  input word valid.
- in_data_i  input  DATA_W  input payload.
- in_ready_o  output  1  dispatcher can accept this cycle (combinational).
- out_valid_o  output  NUM_PORTS  per-port slot valid (registered).
- out_data_o  output  NUM_PORTS*DATA_W  per-port payload; port i occupies bits [i*DATA_W +: DATA_W] (registered).
- out_ready_i  input  NUM_PORTS  per-port consumer ready.
- dispatch_o  output  NUM_PORTS  one-hot target port of the current-cycle accept; all-zero when no accept (combinational).

Behaviour:
- State: priority pointer ptr ($clog2(NUM_PORTS) bits); per-port slot valid and slot data.
- Port i is available when out_valid_o[i]==0 or out_ready_i[i]==1. Draining and reloading a slot in the same cycle is allowed.
- Target selection: the first available port scanning ptr, ptr+1, …, NUM_PORTS-1, 0, …, ptr-1 (modulo NUM_PORTS).
- Unavailable ports are skipped. Skipped ports receive no credit for the skip.
- in_ready_o = OR of all port-available bits. It does not depend on in_valid_i.
- Accept occurs when in_valid_i && in_ready_o. dispatch_o is one-hot at the target and zero otherwise; it never has more than one bit set.
- On accept, at the next edge:
  - target slot valid <= 1
  - target slot data <= in_data_i
  - ptr <= (target+1) mod NUM_PORTS; wraps NUM_PORTS-1 -> 0, including non-power-of-two NUM_PORTS.
- No accept: ptr holds.
- Drain: when out_valid_o[i] && out_ready_i[i] and port i is not the target this cycle, slot valid clears at the next edge.
- Simultaneous drain and load on the same port: valid stays 1 and data takes the new word. No bubble.
- Latency: 1 cycle, input accept to out_valid_o.
- Throughput: one word per cycle while any port is available.
- All ports full and none ready: in_ready_o=0, dispatch_o=0, no state change.
- out_data_o of a non-valid slot holds its last value. Consumers must not sample it.
- Ordering guarantee is per port only. No global reordering buffer.
- Reset (asynchronous, at any time, including mid-stream):
  - ptr=0, all slot valids=0, slot data=0.
  - out_valid_o=0, out_data_o=0.
  - in_ready_o=1 and dispatch_o=0 in the reset state with in_valid_i low.
  - Words held in slots are discarded. No accept happens while reset is high.

Optional Feature:
- Macro: RR_DISPATCHER_STATS_EN.
- When defined: adds output port accept_cnt_o, 16 bits per port (NUM_PORTS*16 total).
  - Port i's counter increments at the edge following each accept targeting port i.
  - Counters saturate at 16'hFFFF.
  - Reset to 0 by reset.
- When undefined: the port and counters do not exist. All other behaviour is identical.

Test Plan:
1. Round-robin order: NUM_PORTS=4, all out_ready_i=4'b1111, in_valid_i=1 for 6 cycles with data 0x10..0x15 -> dispatch_o sequence 0001,0010,0100,1000,0001,0010; port0 receives 0x10 then 0x14; ptr ends at 2.
2. Skip busy port: fill port1 (out_ready_i[1]=0); ptr=1; push 0xA5 -> goes to port2, dispatch_o=0100, ptr=3; port1 slot unchanged.
3. Full backpressure: all four slots valid, out_ready_i=0 -> in_ready_o=0, dispatch_o=0, state frozen 3 cycles. Raise out_ready_i[3] -> next accept targets port3 regardless of ptr.
4. Same-cycle drain and load: ptr=0, port0 valid with 0x11, out_ready_i[0]=1, push 0x22 -> port0 out_valid_o stays 1 and shows 0x22 next cycle; dispatch_o=0001.
5. Non-power-of-two wrap: NUM_PORTS=3, continuous traffic 7 words -> targets 0,1,2,0,1,2,0; ptr never reaches 3.
6. Reset mid-stream: assert reset with 3 slots valid and ptr=2 -> out_valid_o=0 immediately (asynchronous), ptr=0. First post-reset accept dispatch_o=0001. With RR_DISPATCHER_STATS_EN, all counters read 0.

Source files
------------

// File: rtl/rr_dispatcher.sv
// -----------------------------------------------------------------------------
// rr_dispatcher
//
// Round-robin dispatcher: takes one valid/ready input stream and hands each
// accepted word to one of NUM_PORTS output slots in rotating order. This is the
// 1-to-N counterpart of the N-to-1 round-robin arbiter. Every output port owns
// a single registered slot. A port that cannot take a word this cycle is
// skipped and earns no credit for the skip.
//
// Parameters
//   NUM_PORTS  number of output ports (2..16, need not be a power of two)
//   DATA_W     payload width in bits
//
// Ports
//   clk           clock, all state updates on the rising edge
//   reset         asynchronous, active-high reset
//   in_valid_i    input word valid
//   in_data_i     input payload
//   in_ready_o    a word can be accepted this cycle (combinational)
//   out_valid_o   per-port slot valid (registered)
//   out_data_o    per-port payload, port i at [i*DATA_W +: DATA_W] (registered)
//   out_ready_i   per-port consumer ready
//   dispatch_o    one-hot target of this cycle's accept, zero if no accept
//   accept_cnt_o  per-port 16-bit saturating accept counters, port i at
//                 [i*16 +: 16]; present only when RR_DISPATCHER_STATS_EN is
//                 defined
//
// Optional build macro: RR_DISPATCHER_STATS_EN
// -----------------------------------------------------------------------------
module rr_dispatcher #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid_i,
    input  logic [DATA_W-1:0]             in_data_i,
    output logic                          in_ready_o,
    output logic [NUM_PORTS-1:0]          out_valid_o,
    output logic [NUM_PORTS*DATA_W-1:0]   out_data_o,
    input  logic [NUM_PORTS-1:0]          out_ready_i,
    output logic [NUM_PORTS-1:0]          dispatch_o
`ifdef RR_DISPATCHER_STATS_EN
    ,
    output logic [NUM_PORTS*16-1:0]       accept_cnt_o
`endif
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // Port count and last index in the widths used by the pointer arithmetic.
    localparam logic [PTR_W:0]   NP_EXT   = (PTR_W+1)'(NUM_PORTS);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_PORTS - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PTR_W-1:0]   r_ptr;
    logic [NUM_PORTS-1:0] r_slot_vld;
    logic [DATA_W-1:0]  r_slot_data [NUM_PORTS];

    // -------------------------------------------------------------------------
    // Target selection
    // -------------------------------------------------------------------------
    logic [NUM_PORTS-1:0]   w_avail;
    logic                   w_any_avail;
    logic [2*NUM_PORTS-1:0] w_avail_dbl;
    logic [NUM_PORTS-1:0]   w_avail_rot;
    logic [PTR_W-1:0]       w_off;
    logic [PTR_W:0]         w_sum;
    logic [PTR_W-1:0]       w_target;
    logic                   w_accept;
    logic [NUM_PORTS-1:0]   w_dispatch;
    logic [PTR_W-1:0]       w_ptr_nxt;

    // A slot can take a word when it is empty or is being drained this cycle.
    assign w_avail     = ~r_slot_vld | out_ready_i;
    assign w_any_avail = |w_avail;

    // Rotate the availability vector so that bit 0 corresponds to the port
    // under the pointer; the first set bit is then the scan distance.
    assign w_avail_dbl = {w_avail, w_avail};
    assign w_avail_rot = NUM_PORTS'(w_avail_dbl >> r_ptr);

    always_comb begin
        w_off = '0;
        // Descending scan so the lowest set bit wins.
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (w_avail_rot[k]) begin
                w_off = PTR_W'(k);
            end
        end
    end

    // ptr + offset never exceeds 2*NUM_PORTS-2, so one conditional subtract
    // folds it back into range even for non-power-of-two port counts.
    assign w_sum    = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_target = (w_sum >= NP_EXT) ? PTR_W'(w_sum - NP_EXT) : w_sum[PTR_W-1:0];

    // No word is taken while reset is held, whatever the input does.
    assign w_accept = in_valid_i & w_any_avail & ~reset;

    always_comb begin
        w_dispatch = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_dispatch[i] = w_accept && (w_target == PTR_W'(i));
        end
    end

    assign w_ptr_nxt = (w_target == LAST_IDX) ? '0 : (w_target + PTR_W'(1));

    // -------------------------------------------------------------------------
    // Pointer register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Output slots
    // -------------------------------------------------------------------------
    // A load wins over a drain on the same port, so a slot that is read and
    // refilled in one cycle stays valid with the new word (no bubble).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot_vld <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_slot_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_dispatch[i]) begin
                    r_slot_vld[i]  <= 1'b1;
                    r_slot_data[i] <= in_data_i;
                end else if (out_ready_i[i]) begin
                    r_slot_vld[i]  <= 1'b0;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready_o  = w_any_avail;
    assign out_valid_o = r_slot_vld;
    assign dispatch_o  = w_dispatch;

    always_comb begin
        out_data_o = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            out_data_o[i*DATA_W +: DATA_W] = r_slot_data[i];
        end
    end

`ifdef RR_DISPATCHER_STATS_EN
    // -------------------------------------------------------------------------
    // Per-port accept statistics (saturating)
    // -------------------------------------------------------------------------
    logic [15:0] r_acc_cnt [NUM_PORTS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_acc_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_dispatch[i] && (r_acc_cnt[i] != 16'hFFFF)) begin
                    r_acc_cnt[i] <= r_acc_cnt[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        accept_cnt_o = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            accept_cnt_o[i*16 +: 16] = r_acc_cnt[i];
        end
    end
`else
    // Statistics disabled: no counters and no accept_cnt_o port in this build.
`endif

endmodule

// File: tb/tb_rr_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_rr_dispatcher
//
// Drives two dispatchers (4 ports and 3 ports, 8-bit data) with directed and
// random traffic. A behavioural model of slots, pointer and counters predicts
// every output on each falling edge; directed phases add literal expectations.
// -----------------------------------------------------------------------------
module tb_rr_dispatcher;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 4-port instance
    logic        v4;
    logic [7:0]  d4;
    logic [3:0]  rdy4;
    logic        rdy_o4;
    logic [3:0]  vld4;
    logic [31:0] dat4;
    logic [3:0]  disp4;
    // 3-port instance
    logic        v3;
    logic [7:0]  d3;
    logic [2:0]  rdy3;
    logic        rdy_o3;
    logic [2:0]  vld3;
    logic [23:0] dat3;
    logic [2:0]  disp3;

    logic [63:0] g_cnt4;
    logic [63:0] g_cnt3;

`ifdef RR_DISPATCHER_STATS_EN
    logic [63:0] cnt4;
    logic [47:0] cnt3;
    assign g_cnt4 = cnt4;
    assign g_cnt3 = 64'(cnt3);
`else
    assign g_cnt4 = '0;
    assign g_cnt3 = '0;
`endif

    rr_dispatcher #(.NUM_PORTS(4), .DATA_W(8)) u4 (
        .clk(clk), .reset(reset),
        .in_valid_i(v4), .in_data_i(d4), .in_ready_o(rdy_o4),
        .out_valid_o(vld4), .out_data_o(dat4), .out_ready_i(rdy4),
        .dispatch_o(disp4)
`ifdef RR_DISPATCHER_STATS_EN
        , .accept_cnt_o(cnt4)
`endif
    );

    rr_dispatcher #(.NUM_PORTS(3), .DATA_W(8)) u3 (
        .clk(clk), .reset(reset),
        .in_valid_i(v3), .in_data_i(d3), .in_ready_o(rdy_o3),
        .out_valid_o(vld3), .out_data_o(dat3), .out_ready_i(rdy3),
        .dispatch_o(disp3)
`ifdef RR_DISPATCHER_STATS_EN
        , .accept_cnt_o(cnt3)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model: index 0 = 4-port unit, index 1 = 3-port unit
    // -------------------------------------------------------------------------
    int       m_ptr  [2];
    bit       m_vld  [2][16];
    bit [7:0] m_data [2][16];
    int       m_cnt  [2][16];

    task automatic m_clear(input int u);
        m_ptr[u] = 0;
        for (int p = 0; p < 16; p++) begin
            m_vld[u][p]  = 1'b0;
            m_data[u][p] = 8'h00;
            m_cnt[u][p]  = 0;
        end
    endtask

    // First port, scanning from the pointer with wrap, that is empty or being read.
    function automatic int m_target(input int u, input int n, input logic [15:0] rdy);
        for (int k = 0; k < n; k++) begin
            int p;
            p = (m_ptr[u] + k) % n;
            if (!m_vld[u][p] || rdy[p]) return p;
        end
        return -1;
    endfunction

    task automatic cmp_unit(input int u, input int n, input logic v, input logic [7:0] d,
                            input logic [15:0] rdy, input logic rdy_o, input logic [15:0] vld_o,
                            input logic [63:0] data_o, input logic [15:0] disp_o,
                            input logic [63:0] cnt_o);
        int          t;
        bit          acc;
        logic [15:0] ev;
        logic [15:0] edisp;
        logic [63:0] edat;
        logic [63:0] ecnt;
        string       pfx;
        pfx = (u == 0) ? "u4" : "u3";
        if (reset) m_clear(u);
        t   = m_target(u, n, rdy);
        acc = !reset && v && (t >= 0);
        ev = '0; edat = '0; ecnt = '0;
        for (int p = 0; p < n; p++) begin
            ev[p]          = m_vld[u][p];
            edat[p*8 +: 8] = m_data[u][p];
            ecnt[p*16 +: 16] = 16'(m_cnt[u][p]);
        end
        edisp = acc ? (16'd1 << t) : 16'd0;
        chk({pfx, "_in_ready"}, 64'(rdy_o), 64'(t >= 0));
        chk({pfx, "_dispatch"}, 64'(disp_o), 64'(edisp));
        chk({pfx, "_out_valid"}, 64'(vld_o), 64'(ev));
        chk({pfx, "_out_data"}, data_o, edat);
`ifdef RR_DISPATCHER_STATS_EN
        chk({pfx, "_accept_cnt"}, cnt_o, ecnt);
`else
        if (cnt_o != 64'd0) chk({pfx, "_no_stats"}, cnt_o, 64'd0);
`endif
        // Advance the model to the state after the coming rising edge.
        if (!reset) begin
            for (int p = 0; p < n; p++) begin
                if (acc && p == t) begin
                    m_vld[u][p]  = 1'b1;
                    m_data[u][p] = d;
                    if (m_cnt[u][p] < 65535) m_cnt[u][p]++;
                end else if (rdy[p]) begin
                    m_vld[u][p] = 1'b0;
                end
            end
            if (acc) m_ptr[u] = (t + 1) % n;
        end
    endtask

    // Inputs only change just after a rising edge, so the falling edge sees
    // exactly the values the next rising edge will sample.
    always @(negedge clk) begin
        cmp_unit(0, 4, v4, d4, 16'(rdy4), rdy_o4, 16'(vld4), 64'(dat4), 16'(disp4), g_cnt4);
        cmp_unit(1, 3, v3, d3, 16'(rdy3), rdy_o3, 16'(vld3), 64'(dat3), 16'(disp3), g_cnt3);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1);
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    logic [3:0] exp1 [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [2:0] exp5 [7] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};

    initial begin
        reset = 1'b1;
        v4 = 1'b0; d4 = '0; rdy4 = '0;
        v3 = 1'b0; d3 = '0; rdy3 = '0;
        tick();
        tick();
        chk("rst_in_ready", 64'(rdy_o4), 64'd1);
        chk("rst_out_valid", 64'(vld4), 64'd0);
        chk("rst_dispatch", 64'(disp4), 64'd0);
        chk("rst_out_data", 64'(dat4), 64'd0);
        reset = 1'b0;

        // Round-robin order with every port ready
        rdy4 = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            v4 = 1'b1; d4 = 8'h10 + 8'(k);
            #2;
            chk("rr_dispatch", 64'(disp4), 64'(exp1[k]));
            tick();
        end
        v4 = 1'b0;
        chk("rr_port0_data", 64'(dat4[7:0]), 64'h14);
        chk("rr_model_ptr", 64'(m_ptr[0]), 64'd2);
        v4 = 1'b1; d4 = 8'h16;
        #2;
        chk("rr_next_dispatch", 64'(disp4), 64'b0100);
        tick();
        v4 = 1'b0;
        tick();

        // Skip a busy port: port1 held full, pointer brought to 1
        rdy4 = 4'b1101;
        for (int k = 0; k < 6; k++) begin
            v4 = 1'b1; d4 = 8'h31 + 8'(k);
            tick();
        end
        chk("skip_model_ptr", 64'(m_ptr[0]), 64'd1);
        d4 = 8'hA5;
        #2;
        chk("skip_dispatch", 64'(disp4), 64'b0100);
        tick();
        v4 = 1'b0;
        chk("skip_port1_valid", 64'(vld4[1]), 64'd1);
        chk("skip_port1_data", 64'(dat4[15:8]), 64'h33);
        chk("skip_port2_data", 64'(dat4[23:16]), 64'hA5);
        chk("skip_model_ptr2", 64'(m_ptr[0]), 64'd3);

        // Full backpressure
        rdy4 = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            v4 = 1'b1; d4 = 8'hB0 + 8'(k);
            tick();
        end
        chk("full_out_valid", 64'(vld4), 64'b1111);
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("full_in_ready", 64'(rdy_o4), 64'd0);
            chk("full_dispatch", 64'(disp4), 64'd0);
            tick();
        end
        chk("full_model_ptr", 64'(m_ptr[0]), 64'd1);
        rdy4 = 4'b1000; d4 = 8'hC3;
        #2;
        chk("full_release_dispatch", 64'(disp4), 64'b1000);
        tick();
        v4 = 1'b0;

        // Same-cycle drain and load on port0
        rdy4 = 4'b1111;
        tick();
        rdy4 = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            v4 = 1'b1; d4 = 8'h11 + 8'(k);
            tick();
        end
        rdy4 = 4'b1111; d4 = 8'h22;
        #2;
        chk("dl_dispatch", 64'(disp4), 64'b0001);
        chk("dl_before_data", 64'(dat4[7:0]), 64'h11);
        tick();
        v4 = 1'b0;
        chk("dl_valid", 64'(vld4[0]), 64'd1);
        chk("dl_data", 64'(dat4[7:0]), 64'h22);
        tick();

        // Non-power-of-two wrap on the 3-port unit
        rdy3 = 3'b111;
        for (int k = 0; k < 7; k++) begin
            v3 = 1'b1; d3 = 8'h40 + 8'(k);
            #2;
            chk("wrap3_dispatch", 64'(disp3), 64'(exp5[k]));
            tick();
        end
        v3 = 1'b0;
        chk("wrap3_model_ptr", 64'(m_ptr[1]), 64'd1);

        // Random traffic on both units
        for (int k = 0; k < 3000; k++) begin
            v4 = 1'($urandom); d4 = 8'($urandom); rdy4 = 4'($urandom);
            v3 = 1'($urandom); d3 = 8'($urandom); rdy3 = 3'($urandom);
            tick();
        end
        v4 = 1'b0; v3 = 1'b0;

        // Reset mid-stream: three slots valid, pointer at 2
        rdy4 = 4'b1111; rdy3 = 3'b111;
        tick();
        for (int i = 0; i < 4 && m_ptr[0] != 3; i++) begin
            v4 = 1'b1; d4 = 8'h60 + 8'(i);
            tick();
        end
        v4 = 1'b0;
        tick();
        rdy4 = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            v4 = 1'b1; d4 = 8'h71 + 8'(k);
            tick();
        end
        v4 = 1'b0;
        chk("mid_out_valid", 64'(vld4), 64'b1011);
        chk("mid_model_ptr", 64'(m_ptr[0]), 64'd2);
        reset = 1'b1;
        #1;
        chk("mid_async_valid", 64'(vld4), 64'd0);
        chk("mid_async_data", 64'(dat4), 64'd0);
`ifdef RR_DISPATCHER_STATS_EN
        chk("mid_async_cnt", cnt4, 64'd0);
`endif
        tick();
        reset = 1'b0;
        rdy4 = 4'b1111;
        v4 = 1'b1; d4 = 8'h80;
        #2;
        chk("post_rst_dispatch", 64'(disp4), 64'b0001);
        tick();
        v4 = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
